// File: rtl/id_ex_stage.sv
// id_ex_stage: decode -> ALU pipeline register.
// Selects the ALU operands, including forwarding from EX/MEM and MEM/WB.
// Decodes funct3/funct7 into the 4-bit alu_op.
// Uses a valid/ready handshake with flush.
// Optional macro ILLEGAL_OP_EN adds a registered out_illegal flag for
// undefined funct7 encodings.
module id_ex_stage #(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           insn_type,
    input  logic [2:0]           funct3,
    input  logic                 funct7_b5,
    input  logic [REG_IDX_W-1:0] rs1_idx,
    input  logic [REG_IDX_W-1:0] rs2_idx,
    input  logic [REG_IDX_W-1:0] rd_idx,
    input  logic [XLEN-1:0]      rs1_data,
    input  logic [XLEN-1:0]      rs2_data,
    input  logic [XLEN-1:0]      imm,
    input  logic [XLEN-1:0]      pc,
    input  logic                 flush,
    input  logic                 exm_fwd_valid,
    input  logic [REG_IDX_W-1:0] exm_fwd_rd,
    input  logic [XLEN-1:0]      exm_fwd_data,
    input  logic                 mwb_fwd_valid,
    input  logic [REG_IDX_W-1:0] mwb_fwd_rd,
    input  logic [XLEN-1:0]      mwb_fwd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      alu_a,
    output logic [XLEN-1:0]      alu_b,
    output logic [3:0]           alu_op,
    output logic [REG_IDX_W-1:0] out_rd,
`ifdef ILLEGAL_OP_EN
    output logic                 out_illegal,
`endif
    output logic [XLEN-1:0]      out_pc
);

    localparam logic [1:0] T_R     = 2'b00;
    localparam logic [1:0] T_I     = 2'b01;
    localparam logic [1:0] T_LUI   = 2'b10;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    logic            load;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;
    logic [XLEN-1:0] nxt_a, nxt_b;
    logic [3:0]      nxt_op;

    // x0 reads as zero; otherwise the youngest in-flight writer wins.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [REG_IDX_W-1:0] idx,
        input logic [XLEN-1:0]      rf_data,
        input logic                 exm_v,
        input logic [REG_IDX_W-1:0] exm_rd,
        input logic [XLEN-1:0]      exm_d,
        input logic                 mwb_v,
        input logic [REG_IDX_W-1:0] mwb_rd,
        input logic [XLEN-1:0]      mwb_d
    );
        if (idx == '0)                     return '0;
        else if (exm_v && exm_rd == idx)   return exm_d;
        else if (mwb_v && mwb_rd == idx)   return mwb_d;
        else                               return rf_data;
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready && !flush;

    assign fwd_rs1 = fwd_sel(rs1_idx, rs1_data, exm_fwd_valid, exm_fwd_rd, exm_fwd_data,
                             mwb_fwd_valid, mwb_fwd_rd, mwb_fwd_data);
    assign fwd_rs2 = fwd_sel(rs2_idx, rs2_data, exm_fwd_valid, exm_fwd_rd, exm_fwd_data,
                             mwb_fwd_valid, mwb_fwd_rd, mwb_fwd_data);

    // Operand select and ALU-op decode for the incoming instruction.
    always_comb begin
        nxt_a  = fwd_rs1;
        nxt_b  = imm;
        nxt_op = OP_ADD;
        case (insn_type)
            T_R:     nxt_b = fwd_rs2;
            T_I:     nxt_b = imm;
            T_LUI:   nxt_a = '0;
            default: nxt_a = pc;   // AUIPC
        endcase
        if (insn_type == T_R || insn_type == T_I) begin
            case (funct3)
                3'b000:  nxt_op = (insn_type == T_R && funct7_b5) ? OP_SUB : OP_ADD;
                3'b001:  nxt_op = OP_SLL;
                3'b010:  nxt_op = OP_SLT;
                3'b011:  nxt_op = OP_SLTU;
                3'b100:  nxt_op = OP_XOR;
                3'b101:  nxt_op = funct7_b5 ? OP_SRA : OP_SRL;
                3'b110:  nxt_op = OP_OR;
                default: nxt_op = OP_AND;
            endcase
        end
    end

    // Valid bit: flush beats load, and a drain without load empties the stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          out_valid <= 1'b0;
        else if (flush)      out_valid <= 1'b0;
        else if (load)       out_valid <= 1'b1;
        else if (out_ready)  out_valid <= 1'b0;
    end

    // Payload only moves on load, so it stays frozen while held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            out_rd <= '0;
            out_pc <= '0;
        end else if (load) begin
            alu_a  <= nxt_a;
            alu_b  <= nxt_b;
            alu_op <= nxt_op;
            out_rd <= rd_idx;
            out_pc <= pc;
        end
    end

`ifdef ILLEGAL_OP_EN
    // Flag funct7 encodings that RV32I leaves undefined.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_illegal <= 1'b0;
        else if (load)
            out_illegal <= (insn_type == T_R && funct7_b5 && funct3 != 3'b000 && funct3 != 3'b101)
                        || (insn_type == T_I && funct7_b5 && funct3 == 3'b001);
    end
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode and the `alu` block. It turns decoded RV32I ALU-class instructions into registered `alu_a`, `alu_b` and `alu_op` for the ALU.
- Performs operand selection (rs1/pc/zero, rs2/imm) and ALU-op decode.
- Applies EX/MEM and MEM/WB forwarding.
- Supports a valid/ready handshake, stall and flush.

Parameters:
- XLEN, 32, datapath width.
- REG_IDX_W, 5, register index width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  decode has an instruction
- in_ready  out  1  stage can accept
- insn_type  in  2  00 R-type, 01 I-type ALU, 10 LUI, 11 AUIPC
- funct3  in  3  instruction funct3
- funct7_b5  in  1  instruction bit 30
- rs1_idx, rs2_idx  in  REG_IDX_W  source indices
- rd_idx  in  REG_IDX_W  destination index
- rs1_data, rs2_data  in  XLEN  register-file read data
- imm  in  XLEN  sign-extended/shifted immediate from decode
- pc  in  XLEN  instruction PC
- flush  in  1  kill held and incoming instruction
- exm_fwd_valid  in  1  EX/MEM writes a register
- exm_fwd_rd  in  REG_IDX_W  EX/MEM destination
- exm_fwd_data  in  XLEN  EX/MEM result
- mwb_fwd_valid  in  1  MEM/WB writes a register
- mwb_fwd_rd  in  REG_IDX_W  MEM/WB destination
- mwb_fwd_data  in  XLEN  MEM/WB result
- out_valid  out  1  ALU operands valid
- out_ready  in  1  downstream accepts
- alu_a, alu_b  out  XLEN  to alu.a / alu.b
- alu_op  out  4  to alu.opcode
- out_rd  out  REG_IDX_W  destination index
- out_pc  out  XLEN  carried PC
- out_illegal  out  1  only with ILLEGAL_OP_EN

Behaviour:
- Reset (async, rst_n=0): all outputs and registers are 0, so out_valid=0, alu_op=0000, alu_a=alu_b=0, out_rd=0, out_pc=0, out_illegal=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Load occurs when in_valid && in_ready && !flush; registers update on that edge, out_valid=1 next cycle, latency 1.
  - out_valid held with !out_ready: all outputs frozen, in_ready=0.
  - Drain without load: out_valid -> 0.
- Flush:
  - flush=1 on an edge clears out_valid regardless of in_valid/out_ready (priority over load).
  - Data registers may hold stale values.
  - in_ready is not gated by flush.
- Forwarding, per source (rs1 and rs2 independently), evaluated at load time:
  - idx==0: operand is 0.
  - Otherwise, exm_fwd_valid && exm_fwd_rd==idx: operand is exm_fwd_data.
  - Otherwise, mwb_fwd_valid && mwb_fwd_rd==idx: operand is mwb_fwd_data.
  - Otherwise: operand is the regfile data.
  - When both EX/MEM and MEM/WB match, EX/MEM wins.
- Operand select:
  - R: a=fwd_rs1, b=fwd_rs2.
  - I: a=fwd_rs1, b=imm.
  - LUI: a=0, b=imm.
  - AUIPC: a=pc, b=imm.
- alu_op encoding: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLT, 1001 SLTU.
- funct3 decode (R and I):

  | funct3 | op |
  |---|---|
  | 000 | ADD; SUB only if R && funct7_b5 |
  | 001 | SLL |
  | 010 | SLT |
  | 011 | SLTU |
  | 100 | XOR |
  | 101 | SRL, or SRA if funct7_b5 |
  | 110 | OR |
  | 111 | AND |

- LUI and AUIPC always use ADD.
- I-type 000 with funct7_b5=1 is ADDI, never SUB.
- Undefined funct7_b5 combinations decode as the funct3 base op.
- Reset mid-operation: held instruction is discarded immediately; no output glitches beyond the reset-value drive.

Optional Feature:
- ILLEGAL_OP_EN defined:
  - out_illegal is registered alongside the operands.
  - It is 1 for R-type with funct7_b5=1 and funct3 not in {000,101}.
  - It is 1 for I-type with funct3=001 and funct7_b5=1.
  - alu_op is still decoded as above; out_illegal is cleared on reset.
- ILLEGAL_OP_EN undefined: port and logic absent.

Test Plan:
- Reset, then R-type funct3=000 funct7_b5=0, rs1_data=5, rs2_data=10, out_ready=1 -> next cycle out_valid=1, alu_a=5, alu_b=10, alu_op=0000.
- R-type funct3=000 funct7_b5=1, rs1=x3 (data 20), rs2=x4 (data 6) -> alu_op=0001, a=20, b=6.
- R-type funct3=111, rs1=x1 (data 0xAAAAAAAA), rs2=x2 (data 0x55555555), with exm_fwd_valid=1, exm_fwd_rd=1, exm_fwd_data=0x12345678 and mwb_fwd_rd=1 -> alu_a=0x12345678 (EX/MEM wins), alu_b=0x55555555, alu_op=0010.
- AUIPC pc=0x1000 imm=0x20000, and LUI imm=0xABCDE000 -> (0x1000, 0x20000, 0000) then (0, 0xABCDE000, 0000); rs1_idx=0 with matching exm_fwd_rd=0 -> operand 0.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs frozen; then flush=1 -> out_valid=0 next cycle.
- With ILLEGAL_OP_EN, R-type funct3=100 funct7_b5=1 -> out_illegal=1, alu_op=0100.
- With ILLEGAL_OP_EN, rst_n pulsed low mid-hold -> all outputs 0 asynchronously.
